// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, major opcodes used by the
// downstream stages, and the fetch-buffer entry layout (PC + instruction).
package riscv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [6:0] {
        OP_LD  = 7'b0000011,
        OP_SD  = 7'b0100011,
        OP_BEQ = 7'b1100011,
        OP_ALU = 7'b0110011
    } opcode_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a registered occupancy count and a flush.
// Ports: clock, reset_n (async, active-low), push/din, pop/dout (head, valid
// when !empty), flush (empties the queue, overrides push/pop), full, empty,
// count (current occupancy).
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic [63:0],
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues word reads to a pipelined
// IMEM (valid/ready request, in-order responses), buffers responses so a
// stall loses nothing, and drives the IF/ID register.
// Ports: clock, reset_n (async, active-low); stall, redirect_valid/redirect_pc
// from hazard unit / EX; imem_req_* request channel; imem_rsp_* response
// channel; ifid_ir/ifid_pc/ifid_valid to decode.
module riscv_fetch_stage
    import riscv_pipe_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic [31:0]       ifid_ir,
    output logic [63:0]       ifid_pc,
    output logic              ifid_valid
);

    localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
    localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]   pc;
    logic [IW-1:0] inflight;
    logic [IW-1:0] drop_cnt;
    logic [IW-1:0] mask_cnt;

    logic         accept, rsp_live, rsp_drop, rsp_keep, advance, bypass;
    logic         buf_push, buf_pop, buf_full, buf_empty;
    logic [FW-1:0] buf_count;
    fetch_entry_t buf_in, buf_head;
    logic         tag_full, tag_empty;
    logic [IW-1:0] tag_count;
    logic [63:0]  tag_head;

    assign imem_req_addr = pc[ADDR_W+1:2];

    always_comb begin
        // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
        rsp_live = imem_rsp_valid && (inflight != '0);
        rsp_drop = rsp_live && (drop_cnt != '0);
        rsp_keep = rsp_live && (drop_cnt == '0);
        // Credit rule: buffered + outstanding never exceeds the buffer depth.
        imem_req_valid = reset_n && !redirect_valid
                         && ((32'(buf_count) + 32'(inflight)) < FIFO_DEPTH)
                         && (32'(inflight) < MAX_INFLIGHT);
        accept   = imem_req_valid && imem_req_ready;
        advance  = !redirect_valid && !stall;
        buf_pop  = advance && !buf_empty;
        bypass   = advance && buf_empty && rsp_keep;
        buf_push = !redirect_valid && rsp_keep && !bypass;
        buf_in   = '{pc: tag_head, ir: imem_rsp_data};
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_ibuf (
        .clock(clock), .reset_n(reset_n),
        .push(buf_push), .pop(buf_pop), .flush(redirect_valid),
        .din(buf_in), .dout(buf_head),
        .full(buf_full), .empty(buf_empty), .count(buf_count)
    );

    fetch_fifo #(.DEPTH(MAX_INFLIGHT), .T(logic [63:0])) u_pctag (
        .clock(clock), .reset_n(reset_n),
        .push(accept), .pop(rsp_keep && !redirect_valid), .flush(redirect_valid),
        .din(pc), .dout(tag_head),
        .full(tag_full), .empty(tag_empty), .count(tag_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            mask_cnt   <= '0;
            ifid_ir    <= NOP_INSTR;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else begin
            if (32'(mask_cnt) < MAX_INFLIGHT) mask_cnt <= mask_cnt + 1'b1;

            case ({accept, rsp_live})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase

            if (redirect_valid) begin
                // Everything still outstanding after this edge is stale.
                pc         <= redirect_pc & ~64'h3;
                drop_cnt   <= inflight - IW'(rsp_live);
                ifid_ir    <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else begin
                if (accept)   pc       <= pc + 64'd4;
                if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
                if (!stall) begin
                    if (!buf_empty) begin
                        ifid_ir    <= buf_head.ir;
                        ifid_pc    <= buf_head.pc;
                        ifid_valid <= 1'b1;
                    end else if (rsp_keep) begin
                        ifid_ir    <= imem_rsp_data;
                        ifid_pc    <= tag_head;
                        ifid_valid <= 1'b1;
                    end else begin
                        ifid_ir    <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end
            end

            assert (!(buf_push && buf_full && !buf_pop))
                else $error("fetch buffer overflow");
            assert (!(accept && tag_full))
                else $error("pc-tag queue overflow");
            assert (!(rsp_keep && tag_empty))
                else $error("response without pc tag");
            assert ((32'(tag_count) + 32'(drop_cnt)) == 32'(inflight))
                else $error("pc-tag queue out of step with inflight count");
            if (32'(mask_cnt) == MAX_INFLIGHT)
                assert (!(imem_rsp_valid && (inflight == '0)))
                    else $error("imem response with nothing in flight");
        end
    end

endmodule
